// File: rtl/fp_addsub_pipe_if.sv
// Handshake and data bundle for fp_addsub_pipe.
// Flags exists only when FP_ADDSUB_FLAGS_EN is defined.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   InValid;
    logic                   InReady;
    logic [EXP_W+MAN_W:0]   Op1;
    logic [EXP_W+MAN_W:0]   Op2;
    logic                   Sub;
    logic                   OutValid;
    logic                   OutReady;
    logic [EXP_W+MAN_W:0]   Result;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]             Flags;

    modport master (output InValid, Op1, Op2, Sub, OutReady,
                    input  InReady, OutValid, Result, Flags);
    modport slave  (input  InValid, Op1, Op2, Sub, OutReady,
                    output InReady, OutValid, Result, Flags);
`else
    modport master (output InValid, Op1, Op2, Sub, OutReady,
                    input  InReady, OutValid, Result);
    modport slave  (input  InValid, Op1, Op2, Sub, OutReady,
                    output InReady, OutValid, Result);
`endif
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: input capture, align, add, normalise, round/pack.
// Define FP_ADDSUB_FLAGS_EN to build the {Invalid, Overflow, Underflow, Inexact} Flags output.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              Clock,
    input  logic              Reset,
    fp_addsub_pipe_if.slave   bus
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int F   = MAN_W + 4;
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(F + 1);
    localparam logic [EXP_W-1:0]         EMAX = '1;
    localparam logic signed [XW-1:0]     EINF = XW'(2**EXP_W - 1);
    localparam logic signed [XW-1:0]     EZERO = '0;
    localparam logic signed [XW-1:0]     EONE = XW'(1);

    function automatic logic [LZW-1:0] lzc(input logic [F-1:0] x);
        lzc = LZW'(F);
        for (int i = 0; i < F; i++)
            if (x[i]) lzc = LZW'(F - 1 - i);
    endfunction

    logic stall, adv;
    logic v0, v1, v2, v3, vout;
    logic [W-1:0] in_a, in_b, res_q;
    logic in_sub;

    logic sa, sb, za, zb, nana, nanb, infa, infb, swap;
    logic [W-2:0] ka, kb;
    logic [EXP_W-1:0] ea, eb, el, es, d;
    logic [MAN_W:0] ma, mb, mlg, msm;
    logic [F-1:0] al;
    logic [2*F-1:0] wide;
    logic nan1, inf1;

    logic s1_sign, s1_subop, s1_zsign, s1_nan, s1_inf, s1_isign;
    logic [EXP_W-1:0] s1_exp;
    logic [F-1:0] s1_fl, s1_fs;

    logic s2_sign, s2_zsign, s2_nan, s2_inf, s2_isign;
    logic [EXP_W-1:0] s2_exp;
    logic [F:0] s2_sum;

    logic [LZW-1:0] lz;
    logic [F-1:0] nm;
    logic signed [XW-1:0] ne;

    logic s3_sign, s3_zsign, s3_zero, s3_nan, s3_inf, s3_isign;
    logic signed [XW-1:0] s3_exp;
    logic [F-1:0] s3_man;

    logic inc, grs, ovf, unf;
    logic [MAN_W+1:0] rm;
    logic [MAN_W-1:0] rf;
    logic signed [XW-1:0] re;
    logic [W-1:0] res_d;
    logic [3:0] flg_d;

    // The whole pipeline freezes while the output is held, so no bubble is ever squeezed out.
    assign stall       = vout && !bus.OutReady;
    assign adv         = !stall;
    assign bus.InReady = !stall;
    assign bus.OutValid = vout;
    assign bus.Result  = res_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            {v0, v1, v2, v3, vout} <= '0;
        end else if (adv) begin
            v0   <= bus.InValid;
            v1   <= v0;
            v2   <= v1;
            v3   <= v2;
            vout <= v3;
        end
    end

    always_comb begin
        sa   = in_a[W-1];
        sb   = in_b[W-1] ^ in_sub;
        ea   = in_a[W-2:MAN_W];
        eb   = in_b[W-2:MAN_W];
        za   = (ea == '0);
        zb   = (eb == '0);
        nana = (ea == EMAX) && (in_a[MAN_W-1:0] != '0);
        nanb = (eb == EMAX) && (in_b[MAN_W-1:0] != '0);
        infa = (ea == EMAX) && (in_a[MAN_W-1:0] == '0);
        infb = (eb == EMAX) && (in_b[MAN_W-1:0] == '0);
        ka   = za ? '0 : in_a[W-2:0];
        kb   = zb ? '0 : in_b[W-2:0];
        swap = kb > ka;
        ma   = za ? '0 : {1'b1, in_a[MAN_W-1:0]};
        mb   = zb ? '0 : {1'b1, in_b[MAN_W-1:0]};
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        mlg  = swap ? mb : ma;
        msm  = swap ? ma : mb;
        d    = el - es;
        wide = {msm, 3'b000, {F{1'b0}}} >> d;
        // Past the round position only the sticky OR of the small mantissa survives.
        if (32'(d) >= 32'(MAN_W + 3))
            al = {{(F-1){1'b0}}, |msm};
        else
            al = {wide[2*F-1:F+1], wide[F] | (|wide[F-1:0])};
        nan1 = nana || nanb || (infa && infb && (sa != sb));
        inf1 = (infa || infb) && !nan1;
    end

    always_comb begin
        lz = lzc(s2_sum[F-1:0]);
        if (s2_sum[F]) begin
            nm = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
            ne = $signed({2'b00, s2_exp}) + EONE;
        end else begin
            nm = s2_sum[F-1:0] << lz;
            ne = $signed({2'b00, s2_exp}) - $signed(XW'(lz));
        end
    end

    always_comb begin
        inc = s3_man[2] & (s3_man[1] | s3_man[0] | s3_man[3]);
        grs = |s3_man[2:0];
        rm  = {1'b0, s3_man[F-1:3]} + (MAN_W+2)'(inc);
        re  = s3_exp + $signed(XW'(rm[MAN_W+1]));
        rf  = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
        ovf = re >= EINF;
        unf = re <= EZERO;
        res_d = {s3_sign, re[EXP_W-1:0], rf};
        flg_d = '0;
        if (s3_nan) begin
            res_d = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            flg_d = 4'b1000;
        end else if (s3_inf) begin
            res_d = {s3_isign, EMAX, {MAN_W{1'b0}}};
        end else if (s3_zero) begin
            res_d = {s3_zsign, {(W-1){1'b0}}};
        end else if (ovf) begin
            res_d = {s3_sign, EMAX, {MAN_W{1'b0}}};
            flg_d = 4'b0101;
        end else if (unf) begin
            res_d = {s3_sign, {(W-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            flg_d = {3'b000, grs};
        end
    end

    // Datapath registers carry no reset; the valid bits above decide what is live.
    always_ff @(posedge Clock) begin
        if (adv) begin
            in_a     <= bus.Op1;
            in_b     <= bus.Op2;
            in_sub   <= bus.Sub;

            s1_sign  <= swap ? sb : sa;
            s1_exp   <= el;
            s1_fl    <= {mlg, 3'b000};
            s1_fs    <= al;
            s1_subop <= sa ^ sb;
            s1_zsign <= sa & sb;
            s1_nan   <= nan1;
            s1_inf   <= inf1;
            s1_isign <= infa ? sa : sb;

            s2_sum   <= s1_subop ? ({1'b0, s1_fl} - {1'b0, s1_fs})
                                 : ({1'b0, s1_fl} + {1'b0, s1_fs});
            s2_exp   <= s1_exp;
            s2_sign  <= s1_sign;
            s2_zsign <= s1_zsign;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_isign <= s1_isign;

            s3_man   <= nm;
            s3_exp   <= ne;
            s3_zero  <= (s2_sum == '0);
            s3_sign  <= s2_sign;
            s3_zsign <= s2_zsign;
            s3_nan   <= s2_nan;
            s3_inf   <= s2_inf;
            s3_isign <= s2_isign;
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0] flg_q;
    assign bus.Flags = flg_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (adv) begin
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end
`else
    always_ff @(posedge Clock) begin
        if (Reset)
            res_q <= '0;
        else if (adv)
            res_q <= res_d;
    end
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Randomised scoreboard bench for fp_addsub_pipe against an exact wide-integer reference model.
module tb_fp_addsub_pipe;
    logic Clock = 1'b0;
    logic Reset;

    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int readyMode = 0;
    int outCount = 0;
    int stallSeen = 0;
    bit checkLat = 0;
    logic [35:0] expQ[$];
    int accQ[$];
    logic [35:0] monExp;
    int monAcc;

    logic [31:0] dirA [9] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000,
                              32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'hFF800000};
    logic [31:0] dirB [9] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33C00000,
                              32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000};
    logic        dirS [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [35:0] dirE [9] = '{36'h0_40000000, 36'h0_00000000, 36'h0_80000000, 36'h1_3F800000,
                              36'h1_3F800001, 36'h1_3F800002, 36'h5_7F800000, 36'h8_7FC00000,
                              36'h0_FF800000};
    logic [31:0] specials [8] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000000,
                                  32'h80000000, 32'h7F7FFFFF, 32'h00800000, 32'h00000001};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Exact reference: both operands become integers on a common 2^(1-bias-23) grid.
    function automatic logic [35:0] refModel(input logic [31:0] a, input logic [31:0] b, input logic subOp);
        logic sa, sb, sign, up, inexact;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic [319:0] ma, mb, mag, kept, rem, half;
        int p, sh, e;
        sa = a[31];
        sb = b[31] ^ subOp;
        ea = a[30:23];
        eb = b[30:23];
        fa = a[22:0];
        fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb))
            return {4'b1000, 32'h7FC00000};
        if (ea == 8'hFF) return {4'b0000, sa, 8'hFF, 23'd0};
        if (eb == 8'hFF) return {4'b0000, sb, 8'hFF, 23'd0};
        ma = (ea == 0) ? 320'd0 : (320'({1'b1, fa}) << (ea - 8'd1));
        mb = (eb == 0) ? 320'd0 : (320'({1'b1, fb}) << (eb - 8'd1));
        if (sa == sb) begin
            mag = ma + mb;
            sign = sa;
        end else if (ma >= mb) begin
            mag = ma - mb;
            sign = sa;
        end else begin
            mag = mb - ma;
            sign = sb;
        end
        if (mag == 0) return {4'b0000, sa & sb, 31'd0};
        p = 0;
        for (int i = 0; i < 320; i++)
            if (mag[i]) p = i;
        e = p - 22;
        if (p > 23) begin
            sh = p - 23;
            kept = mag >> sh;
            rem = mag - (kept << sh);
            half = 320'd1 << (sh - 1);
            up = (rem > half) || (rem == half && kept[0]);
            inexact = (rem != 0);
            kept = kept + 320'(up);
            if (kept[24]) begin
                kept = kept >> 1;
                e++;
            end
        end else begin
            kept = mag << (23 - p);
            inexact = 1'b0;
        end
        if (e >= 255) return {4'b0101, sign, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, sign, 31'd0};
        return {3'b000, inexact, sign, 8'(e), kept[22:0]};
    endfunction

    function automatic logic [31:0] randOp(input logic [31:0] near);
        int r, e;
        logic [31:0] v;
        r = int'($urandom_range(0, 9));
        v = $urandom();
        if (r == 0) return v;
        if (r == 1) return specials[$urandom_range(0, 7)];
        if (r < 6) e = int'(near[30:23]) + int'($urandom_range(0, 4)) - 2;
        else if (r == 9) e = int'($urandom_range(1, 6));
        else e = int'($urandom_range(90, 170));
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        if (r == 2) v[22:0] = near[22:0] ^ 23'($urandom_range(0, 7));
        v[30:23] = 8'(e);
        return v;
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [35:0] e);
        bit done;
        done = 0;
        bus.Op1 = a;
        bus.Op2 = b;
        bus.Sub = s;
        bus.InValid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clock);
            if (bus.InReady) begin
                expQ.push_back(e);
                accQ.push_back(cycle + 1);
                done = 1;
            end
        end
        checkOutput("accept", 64'(done), 64'd1);
        @(posedge Clock);
        #1;
        bus.InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        checkOutput("drain", 64'(expQ.size()), 64'd0);
        @(posedge Clock);
        #1;
    endtask

    always @(posedge Clock) cycle++;

    // Sole driver of OutReady: always-ready, random, or the fixed backpressure window.
    initial begin
        int k;
        k = 0;
        bus.OutReady = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            if (readyMode == 2) begin
                bus.OutReady = !(k >= 3 && k <= 10);
                k++;
            end else begin
                k = 0;
                bus.OutReady = (readyMode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    always @(negedge Clock) begin
        if (Reset) begin
            expQ.delete();
            accQ.delete();
        end else begin
            if (bus.OutValid && !bus.OutReady) begin
                stallSeen++;
                checkOutput("inready_stall", 64'(bus.InReady), 64'd0);
            end
            if (bus.OutValid && bus.OutReady) begin
                outCount++;
                checkOutput("sb_nonempty", 64'(expQ.size() > 0), 64'd1);
                if (expQ.size() > 0) begin
                    monExp = expQ.pop_front();
                    monAcc = accQ.pop_front();
                    checkOutput("result", 64'(bus.Result), 64'(monExp[31:0]));
`ifdef FP_ADDSUB_FLAGS_EN
                    checkOutput("flags", 64'(bus.Flags), 64'(monExp[35:32]));
`endif
                    if (checkLat) checkOutput("latency", 64'(cycle - monAcc), 64'd4);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic s;
        int outBefore;
        Reset = 1'b1;
        bus.InValid = 1'b0;
        bus.Op1 = '0;
        bus.Op2 = '0;
        bus.Sub = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkOutput("reset_outvalid", 64'(bus.OutValid), 64'd0);
        checkOutput("reset_result", 64'(bus.Result), 64'd0);
        checkOutput("reset_inready", 64'(bus.InReady), 64'd1);
        @(posedge Clock);
        #1;

        $display("[TB] directed vectors");
        checkLat = 1;
        for (int i = 0; i < 9; i++) applyStimulus(dirA[i], dirB[i], dirS[i], dirE[i]);
        drain();

        $display("[TB] random traffic with random OutReady");
        checkLat = 0;
        readyMode = 1;
        for (int i = 0; i < 300; i++) begin
            a = randOp($urandom());
            b = randOp(a);
            s = 1'($urandom_range(0, 1));
            applyStimulus(a, b, s, refModel(a, b, s));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clock);
                #1;
            end
        end
        drain();
        readyMode = 0;
        @(posedge Clock);
        #1;

        $display("[TB] backpressure window");
        stallSeen = 0;
        outBefore = outCount;
        readyMode = 2;
        for (int i = 0; i < 8; i++) begin
            a = randOp(32'h3F800000);
            b = randOp(a);
            s = 1'(i % 2);
            applyStimulus(a, b, s, refModel(a, b, s));
        end
        drain();
        checkOutput("bp_stall_seen", 64'(stallSeen > 0), 64'd1);
        checkOutput("bp_count", 64'(outCount - outBefore), 64'd8);
        readyMode = 0;
        @(posedge Clock);
        #1;

        $display("[TB] reset with operations in flight");
        checkLat = 1;
        for (int i = 0; i < 3; i++) applyStimulus(dirA[i+3], dirB[i+3], dirS[i+3], dirE[i+3]);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (i == 0) checkOutput("post_reset_inready", 64'(bus.InReady), 64'd1);
            checkOutput("post_reset_outvalid", 64'(bus.OutValid), 64'd0);
        end
        @(posedge Clock);
        #1;
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 36'h0_40000000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
